// File: rtl/eth_pkt_pkg.sv
// eth_pkt_pkg: shared state encoding, type-ONE layout defaults and counter sizing
package eth_pkt_pkg;
  typedef enum logic [2:0] {IDLE, HDR, PAY, DROP, DONE} state_t;
  localparam int TYPE_ONE_HDR_LEN = 120;
  localparam int TYPE_ONE_PAYLOAD_OFS = 124;
  localparam int TYPE_ONE_PAYLOAD_LEN = 400;
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction
endpackage

// File: rtl/our_data_extract_byte_packer.sv
// byte_packer: places bytes into output-word lanes and emits full or flushed words
module byte_packer #(
  parameter int OUT_BYTES = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             byte_in,
  input  logic                   valid,
  input  logic                   flush,
  input  logic                   clear,
  output logic [8*OUT_BYTES-1:0] word,
  output logic                   word_valid
);
  localparam int IW = OUT_BYTES > 1 ? $clog2(OUT_BYTES) : 1;
  logic [8*OUT_BYTES-1:0] acc_q, acc_d;
  logic [IW-1:0] idx_q, idx_d;
  // merge the incoming byte into its lane; unfilled lanes stay zero, which pads a flushed word
  always_comb begin
    word = acc_q;
    for (int i = 0; i < OUT_BYTES; i++)
      if (idx_q == IW'(MSB_FIRST ? OUT_BYTES - 1 - i : i)) word[8*i +: 8] = byte_in;
    word_valid = valid && (idx_q == IW'(OUT_BYTES - 1) || flush);
    acc_d = (clear || word_valid) ? '0 : valid ? word : acc_q;
    idx_d = (clear || word_valid) ? '0 : valid ? idx_q + 1'b1 : idx_q;
  end
  // hold the partially filled word between bytes
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      idx_q <= '0;
    end else begin
      acc_q <= acc_d;
      idx_q <= idx_d;
    end
  end
endmodule

// File: rtl/our_data_extract.sv
// our_data_extract: extracts a fixed payload window of a typed packet into packed FIFO words
module our_data_extract
  import eth_pkt_pkg::*;
#(
  parameter int HDR_LEN     = TYPE_ONE_HDR_LEN,
  parameter int PAYLOAD_OFS = TYPE_ONE_PAYLOAD_OFS,
  parameter int PAYLOAD_LEN = TYPE_ONE_PAYLOAD_LEN,
  parameter int OUT_BYTES   = 2,
  parameter bit MSB_FIRST   = 1'b1,
  parameter int PKT_CNT_W   = 16
) (
  input  logic                   clock,
  input  logic                   sclr,
  input  logic [7:0]             datain,
  input  logic                   ena,
  input  logic                   fifo_afull,
  output logic                   wren,
  output logic [8*OUT_BYTES-1:0] data,
  output logic                   last,
  output logic                   header_ena,
  output logic                   err_short,
  output logic                   err_ovf,
  output logic [PKT_CNT_W-1:0]   pkt_cnt
);
  localparam int END = PAYLOAD_OFS + PAYLOAD_LEN;
  localparam int CW = cnt_w(END);
  localparam logic [CW-1:0] C_END = CW'(END);
  localparam logic [CW-1:0] C_LAST = CW'(END - 1);
  localparam logic [CW-1:0] C_OFS = CW'(PAYLOAD_OFS);
  localparam logic [CW-1:0] C_HDR = CW'(HDR_LEN - 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [8*OUT_BYTES-1:0] data_q, data_d, word;
  logic [PKT_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic ena_q, ena_d, wren_q, wren_d, last_q, last_d, hdr_q, hdr_d;
  logic err_short_q, err_short_d, err_ovf_q, err_ovf_d;
  logic start, in_hdr, pay_byte, last_byte, word_valid, ovf;
  byte_packer #(.OUT_BYTES(OUT_BYTES), .MSB_FIRST(MSB_FIRST)) u_packer (
    .clk(clock), .rst(sclr), .byte_in(datain), .valid(pay_byte), .flush(last_byte),
    .clear(!ena), .word(word), .word_valid(word_valid)
  );
  // packet tracking, next state and registered-output values; a start needs ena to have been low,
  // so a packet cut by sclr is ignored until ena drops
  always_comb begin
    start = ena && !ena_q && state_q == IDLE;
    in_hdr = start || state_q == HDR;
    pay_byte = ena && ((in_hdr && cnt_q == C_OFS) || state_q == PAY);
    last_byte = pay_byte && cnt_q == C_LAST;
    ovf = word_valid && fifo_afull;
    ena_d = ena;
    cnt_d = !ena ? '0 : (cnt_q == C_END) ? cnt_q : cnt_q + 1'b1;
    state_d = !ena ? IDLE : ovf ? DROP : last_byte ? DONE : pay_byte ? PAY : in_hdr ? HDR : state_q;
    hdr_d = ena && (hdr_q || ((start || state_q != IDLE) && cnt_q == C_HDR));
    wren_d = word_valid && !fifo_afull;
    data_d = wren_d ? word : '0;
    last_d = wren_d && last_byte;
    err_short_d = !ena && (state_q == HDR || state_q == PAY);
    err_ovf_d = ovf;
    pkt_cnt_d = pkt_cnt_q + PKT_CNT_W'(last_d);
  end
  // state and output registers; reset leaves ena_q high to block a packet already in flight
  always_ff @(posedge clock) begin
    if (sclr) begin
      state_q <= IDLE;
      cnt_q <= '0;
      ena_q <= 1'b1;
      wren_q <= 1'b0;
      data_q <= '0;
      last_q <= 1'b0;
      hdr_q <= 1'b0;
      err_short_q <= 1'b0;
      err_ovf_q <= 1'b0;
      pkt_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ena_q <= ena_d;
      wren_q <= wren_d;
      data_q <= data_d;
      last_q <= last_d;
      hdr_q <= hdr_d;
      err_short_q <= err_short_d;
      err_ovf_q <= err_ovf_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end
  assign wren = wren_q;
  assign data = data_q;
  assign last = last_q;
  assign header_ena = hdr_q;
  assign err_short = err_short_q;
  assign err_ovf = err_ovf_q;
  assign pkt_cnt = pkt_cnt_q;
endmodule

// File: doc/our_data_extract.md
# our_data_extract

Parametrised payload extractor for typed Ethernet data packets. It takes the received byte stream while `ena` marks a packet of the selected type, flags when the header is complete, and packs a fixed payload window into OUT_BYTES-wide words for the downstream FIFO. Relative to the fixed 16-bit type-ONE extractor it adds:
- a configurable window and word width,
- selectable byte order,
- zero-padded final partial words with a `last` marker,
- FIFO back-pressure handling,
- short-packet detection and a delivered-packet counter.

## Interface
- HDR_LEN, 120: number of header bytes; `header_ena` qualifies them.
- PAYLOAD_OFS, 124: byte index (0-based from the first `ena` byte) of the first payload byte.
- PAYLOAD_LEN, 400: number of payload bytes; must be ≥1.
- OUT_BYTES, 2: output word width in bytes; legal values 1, 2, 4.
- MSB_FIRST, 1: 1 = first byte of a word goes to `data[8*OUT_BYTES-1 -: 8]`; 0 = first byte goes to `data[7:0]`.
- PKT_CNT_W, 16: width of `pkt_cnt`.

Ports:
- clock  in  1  single clock; all logic is on the rising edge.
- sclr  in  1  reset, synchronous, active-high.
- datain  in  8  packet byte; valid every cycle `ena`=1.
- ena  in  1  the current byte belongs to a packet of this type; contiguous for the whole packet.
- fifo_afull  in  1  downstream FIFO almost-full; sampled on every word write.
- wren  out  1  write strobe for `data`/`last`.
- data  out  8*OUT_BYTES  packed payload word.
- last  out  1  with `wren`: this is the final word of the packet.
- header_ena  out  1  header fully received; high until `ena` falls.
- err_short  out  1  one-cycle pulse: `ena` fell before the payload completed.
- err_ovf  out  1  one-cycle pulse: a word was dropped because of `fifo_afull`.
- pkt_cnt  out  PKT_CNT_W  count of packets delivered complete; wraps.

## Operation
- The byte counter `cnt` is 0 on the first `ena` byte and increments per `ena` byte. It saturates at PAYLOAD_OFS+PAYLOAD_LEN and is cleared whenever `ena`=0.
- Its width is the minimum that holds PAYLOAD_OFS+PAYLOAD_LEN; the default is 10 bits.
- State machine, states IDLE, HDR, PAY, DROP, DONE:
  - IDLE→HDR on the first `ena` byte.
  - HDR→PAY when the byte with `cnt`=PAYLOAD_OFS is accepted. That byte is packed.
  - PAY→DONE after byte PAYLOAD_OFS+PAYLOAD_LEN-1.
  - PAY→DROP on an overflow.
  - Any state→IDLE when `ena`=0.
- `header_ena` is set on the cycle after the byte with `cnt`=HDR_LEN-1 is accepted.
- Packing in PAY:
  - Bytes fill a word in arrival order, placed according to MSB_FIRST.
  - The word is written when it holds OUT_BYTES bytes, or when the final payload byte arrives. A partial final word is zero-padded in its unfilled byte lanes.
  - `last`=1 accompanies the write of the final word.
- Overflow: `fifo_afull`=1 on the cycle a word is completed means:
  - that word is not written;
  - `err_ovf` pulses;
  - the state moves to DROP, and no further words or `last` are written for the packet.
- Short packet: `ena` falls in HDR or PAY means:
  - `err_short` pulses;
  - any partial word is discarded;
  - no `last` is written and `pkt_cnt` is unchanged.
- Bytes in DONE are ignored.
- `pkt_cnt` increments by 1, mod 2^PKT_CNT_W, on the cycle the `last` word is written.
- Packets must be separated by at least one cycle with `ena`=0. A new packet never shares a word with the previous one.

## Timing
- On `sclr`, every output is 0, the counter and packer are cleared, and the state is IDLE.
- `sclr` overrides `ena` on the same cycle.
- `sclr` in the middle of a packet discards it with no error pulse. Following bytes are ignored until `ena` has been 0 for one cycle.
- All outputs are registered.
- `wren`, `data` and `last` appear 1 cycle after the completing byte is sampled. `wren` is high for exactly 1 cycle per word.
- Default configuration: first write 1 cycle after byte 125 is sampled, last after byte 523. That is 200 writes for OUT_BYTES=2 and 100 for OUT_BYTES=4.
- `err_short` is asserted on the cycle after `ena` is first sampled low.
- `err_ovf` is asserted on the same cycle the dropped word would have been written.
- `fifo_afull` is sampled only on the completing byte's cycle, with no combinational path to the outputs.

## Structure
- Shared package `eth_pkt_pkg` holds:
  - the state enum;
  - default constants for the type-ONE layout: HDR_LEN 120, PAYLOAD_OFS 124, PAYLOAD_LEN 400;
  - a `clog2`-based counter-width function.
- Sub-module `byte_packer`, parameters OUT_BYTES and MSB_FIRST:
  - inputs: byte, valid, flush, clear;
  - outputs: word, word_valid;
  - performs lane placement and zero padding.
- The top level holds the counter, the state machine, error and overflow handling, `pkt_cnt`, and output registers.

## Test plan
- Default parameters; 524-byte packet with bytes equal to `cnt[7:0]` → `header_ena` rises after byte 119; 200 writes; first `data`=0x7C7D; final `data`=0x0A0B with `last`=1; `pkt_cnt`=1.
- OUT_BYTES=4, MSB_FIRST=0, PAYLOAD_LEN=6, same byte pattern → writes 0x7F7E7D7C, then 0x00008180 with `last`; zero padding checked.
- `ena` drops after byte 300 → `err_short` pulse; no `last`; `pkt_cnt` unchanged; next packet delivered intact.
- `fifo_afull`=1 on the completion of the 10th word → `err_ovf` pulse; 9 writes total; no `last`; `pkt_cnt` unchanged.
- `sclr` at byte 200, then `ena` low for 1 cycle and a full packet → all outputs 0 during reset; no error pulse; second packet is complete with `pkt_cnt`=1.
- `pkt_cnt` preset near the wrap value (PKT_CNT_W=4) by sending 16 packets → value wraps 15→0.
